// File: rtl/get_nbrs_address_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : get_nbrs_address_if                                    |
// | Description : Request/result bundle for the neighbour-address        |
// |               generator (cell coordinate in, 8 neighbours out).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface get_nbrs_address_if #(
  parameter int FIELD_W = 4,
  parameter int FIELD_H = 3
);
  localparam int X_ADR_SIZE     = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE     = $clog2(FIELD_H);
  localparam int NEIGHBOURS_CNT = 8;

  logic                  i_valid;
  logic [X_ADR_SIZE-1:0] i_cell_x_adr;
  logic [Y_ADR_SIZE-1:0] i_cell_y_adr;
  logic                  o_valid;
  logic [X_ADR_SIZE-1:0] o_nbrs_x_adr [NEIGHBOURS_CNT];
  logic [Y_ADR_SIZE-1:0] o_nbrs_y_adr [NEIGHBOURS_CNT];
  logic                  o_nbrs_rlvnt [NEIGHBOURS_CNT];

  // Requester side: drives the cell coordinate, receives neighbours
  modport master (
    output i_valid, i_cell_x_adr, i_cell_y_adr,
    input  o_valid, o_nbrs_x_adr, o_nbrs_y_adr, o_nbrs_rlvnt
  );

  // Generator side
  modport slave (
    input  i_valid, i_cell_x_adr, i_cell_y_adr,
    output o_valid, o_nbrs_x_adr, o_nbrs_y_adr, o_nbrs_rlvnt
  );
endinterface
`default_nettype wire

// File: rtl/get_nbrs_address.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : get_nbrs_address                                       |
// | Description : Moore-neighbour coordinate generator for a bounded,    |
// |               non-wrapping field. Registered, 1-cycle latency.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module get_nbrs_address #(
  parameter int FIELD_W = 4,
  parameter int FIELD_H = 3
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst_n,
  get_nbrs_address_if.slave    bus
);
  localparam int X_ADR_SIZE     = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE     = $clog2(FIELD_H);
  localparam int NEIGHBOURS_CNT = 8;

  // Last legal column/row expressed at address width so edge tests never
  // rely on integer extension of the input.
  localparam logic [X_ADR_SIZE-1:0] c_x_last = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] c_y_last = Y_ADR_SIZE'(FIELD_H - 1);

  logic                  cell_in_field;
  logic [X_ADR_SIZE-1:0] cand_x_adr [NEIGHBOURS_CNT];
  logic [Y_ADR_SIZE-1:0] cand_y_adr [NEIGHBOURS_CNT];
  logic                  cand_rlvnt [NEIGHBOURS_CNT];

  logic                  valid_d, valid_q;
  logic [X_ADR_SIZE-1:0] nbrs_x_adr_d [NEIGHBOURS_CNT];
  logic [X_ADR_SIZE-1:0] nbrs_x_adr_q [NEIGHBOURS_CNT];
  logic [Y_ADR_SIZE-1:0] nbrs_y_adr_d [NEIGHBOURS_CNT];
  logic [Y_ADR_SIZE-1:0] nbrs_y_adr_q [NEIGHBOURS_CNT];
  logic                  nbrs_rlvnt_d [NEIGHBOURS_CNT];
  logic                  nbrs_rlvnt_q [NEIGHBOURS_CNT];

  // Non power-of-two fields admit coordinates past the edge; such a cell
  // has no neighbours at all.
  assign cell_in_field = (bus.i_cell_x_adr <= c_x_last) &&
                         (bus.i_cell_y_adr <= c_y_last);

  for (genvar k = 0; k < NEIGHBOURS_CNT; k++) begin : g_nbr
    // Row-major ring around the centre: 0 1 2 / 3 . 4 / 5 6 7
    localparam int c_dx = ((k == 0) || (k == 3) || (k == 5)) ? -1 :
                          ((k == 2) || (k == 4) || (k == 7)) ?  1 : 0;
    localparam int c_dy = (k < 3) ? -1 : (k > 4) ? 1 : 0;

    logic                  x_ok;
    logic                  y_ok;
    logic [X_ADR_SIZE-1:0] x_adr;
    logic [Y_ADR_SIZE-1:0] y_adr;

    if (c_dx < 0) begin : g_x_dec
      assign x_ok  = (bus.i_cell_x_adr != '0);
      assign x_adr = bus.i_cell_x_adr - X_ADR_SIZE'(1);
    end else if (c_dx > 0) begin : g_x_inc
      assign x_ok  = (bus.i_cell_x_adr != c_x_last);
      assign x_adr = bus.i_cell_x_adr + X_ADR_SIZE'(1);
    end else begin : g_x_same
      assign x_ok  = 1'b1;
      assign x_adr = bus.i_cell_x_adr;
    end

    if (c_dy < 0) begin : g_y_dec
      assign y_ok  = (bus.i_cell_y_adr != '0);
      assign y_adr = bus.i_cell_y_adr - Y_ADR_SIZE'(1);
    end else if (c_dy > 0) begin : g_y_inc
      assign y_ok  = (bus.i_cell_y_adr != c_y_last);
      assign y_adr = bus.i_cell_y_adr + Y_ADR_SIZE'(1);
    end else begin : g_y_same
      assign y_ok  = 1'b1;
      assign y_adr = bus.i_cell_y_adr;
    end

    // Irrelevant neighbours report address 0 so downstream never sees junk
    assign cand_rlvnt[k] = cell_in_field & x_ok & y_ok;
    assign cand_x_adr[k] = cand_rlvnt[k] ? x_adr : '0;
    assign cand_y_adr[k] = cand_rlvnt[k] ? y_adr : '0;

    assign bus.o_nbrs_x_adr[k] = nbrs_x_adr_q[k];
    assign bus.o_nbrs_y_adr[k] = nbrs_y_adr_q[k];
    assign bus.o_nbrs_rlvnt[k] = nbrs_rlvnt_q[k];
  end

  assign bus.o_valid = valid_q;

  // Capture a new result on a request, otherwise hold the last one
  always_comb begin
    valid_d      = bus.i_valid;
    nbrs_x_adr_d = nbrs_x_adr_q;
    nbrs_y_adr_d = nbrs_y_adr_q;
    nbrs_rlvnt_d = nbrs_rlvnt_q;
    if (bus.i_valid) begin
      nbrs_x_adr_d = cand_x_adr;
      nbrs_y_adr_d = cand_y_adr;
      nbrs_rlvnt_d = cand_rlvnt;
    end
  end

  // Output registers; reset drops any in-flight result immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      nbrs_x_adr_q <= '{default: '0};
      nbrs_y_adr_q <= '{default: '0};
      nbrs_rlvnt_q <= '{default: 1'b0};
    end else begin
      valid_q      <= valid_d;
      nbrs_x_adr_q <= nbrs_x_adr_d;
      nbrs_y_adr_q <= nbrs_y_adr_d;
      nbrs_rlvnt_q <= nbrs_rlvnt_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_get_nbrs_address.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_get_nbrs_address                                    |
// | Description : Directed self-checking bench for get_nbrs_address on   |
// |               the default 4x3 field.                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_get_nbrs_address;
  localparam int FIELD_W = 4;
  localparam int FIELD_H = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  get_nbrs_address_if #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H)) bus ();

  get_nbrs_address #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs eight 2-bit addresses, k0 in the low bits
  function automatic logic [15:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    return {2'(a7), 2'(a6), 2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  // Reference: integer neighbour arithmetic with explicit bounds test
  task automatic model_cell(input int x, input int y, output logic [7:0] rl,
                            output logic [15:0] ex, output logic [15:0] ey);
    int dxs [8];
    int dys [8];
    dxs = '{-1, 0, 1, -1, 1, -1, 0, 1};
    dys = '{-1, -1, -1, 0, 0, 1, 1, 1};
    rl = '0; ex = '0; ey = '0;
    for (int k = 0; k < 8; k++) begin
      int xx;
      int yy;
      xx = x + dxs[k];
      yy = y + dys[k];
      if (x < FIELD_W && y < FIELD_H && xx >= 0 && xx < FIELD_W && yy >= 0 && yy < FIELD_H) begin
        rl[k]        = 1'b1;
        ex[2*k +: 2] = 2'(xx);
        ey[2*k +: 2] = 2'(yy);
      end
    end
  endtask

  task automatic check(input string tag, input logic exp_v, input logic [7:0] exp_rl,
                       input logic [15:0] exp_x, input logic [15:0] exp_y);
    logic [7:0]  obs_rl;
    logic [15:0] obs_x;
    logic [15:0] obs_y;
    for (int k = 0; k < 8; k++) begin
      obs_rl[k]        = bus.o_nbrs_rlvnt[k];
      obs_x[2*k +: 2]  = bus.o_nbrs_x_adr[k];
      obs_y[2*k +: 2]  = bus.o_nbrs_y_adr[k];
    end
    n_tests++;
    assert (bus.o_valid === exp_v) else begin
      n_fail++;
      $error("FAIL %s valid: observed %b expected %b", tag, bus.o_valid, exp_v);
    end
    n_tests++;
    assert (obs_rl === exp_rl) else begin
      n_fail++;
      $error("FAIL %s rlvnt: observed %b expected %b", tag, obs_rl, exp_rl);
    end
    n_tests++;
    assert (obs_x === exp_x) else begin
      n_fail++;
      $error("FAIL %s x_adr: observed %h expected %h", tag, obs_x, exp_x);
    end
    n_tests++;
    assert (obs_y === exp_y) else begin
      n_fail++;
      $error("FAIL %s y_adr: observed %h expected %h", tag, obs_y, exp_y);
    end
  endtask

  task automatic drive(input logic v, input int x, input int y);
    bus.i_valid      = v;
    bus.i_cell_x_adr = 2'(x);
    bus.i_cell_y_adr = 2'(y);
  endtask

  initial begin
    logic [7:0]  m_rl;
    logic [15:0] m_x;
    logic [15:0] m_y;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    drive(1'b0, 0, 0);

    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1 check("reset", 1'b0, 8'h00, 16'h0000, 16'h0000);

    // Interior cell (1,1)
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1, 1);
    @(negedge clk);
    check("interior_1_1", 1'b1, 8'hFF, pk8(0, 1, 2, 0, 2, 0, 1, 2), pk8(0, 0, 0, 1, 1, 2, 2, 2));

    // Corner (0,0)
    drive(1'b1, 0, 0);
    @(negedge clk);
    check("corner_0_0", 1'b1, 8'hD0, pk8(0, 0, 0, 0, 1, 0, 0, 1), pk8(0, 0, 0, 0, 0, 0, 1, 1));

    // Corner (3,2)
    drive(1'b1, 3, 2);
    @(negedge clk);
    check("corner_3_2", 1'b1, 8'h0B, pk8(2, 3, 0, 2, 0, 0, 0, 0), pk8(1, 1, 0, 2, 0, 0, 0, 0));

    // Idle cycle: valid drops, data holds the (3,2) result
    drive(1'b0, 1, 1);
    @(negedge clk);
    check("hold", 1'b0, 8'h0B, pk8(2, 3, 0, 2, 0, 0, 0, 0), pk8(1, 1, 0, 2, 0, 0, 0, 0));

    // Out-of-range row
    drive(1'b1, 1, 3);
    @(negedge clk);
    check("out_of_range_y3", 1'b1, 8'h00, 16'h0000, 16'h0000);

    // All 12 cells back-to-back
    for (int c = 0; c < FIELD_W * FIELD_H; c++) begin
      drive(1'b1, c % FIELD_W, c / FIELD_W);
      @(negedge clk);
      model_cell(c % FIELD_W, c / FIELD_W, m_rl, m_x, m_y);
      check($sformatf("sweep_%0d_%0d", c % FIELD_W, c / FIELD_W), 1'b1, m_rl, m_x, m_y);
    end

    // Mid-stream reset: request pending, reset before the capturing edge
    drive(1'b1, 1, 1);
    #2 rst_n = 1'b0;
    #1 check("midreset_clear", 1'b0, 8'h00, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1, 1);
    @(negedge clk);
    check("midreset_discard", 1'b0, 8'h00, 16'h0000, 16'h0000);

    // Recovery after reset
    drive(1'b1, 2, 1);
    @(negedge clk);
    check("post_reset_2_1", 1'b1, 8'hFF, pk8(1, 2, 3, 1, 3, 1, 2, 3), pk8(0, 0, 0, 1, 1, 2, 2, 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
